// File: rtl/ras_ctrl.sv
// Return-address-stack sequencer: call/ret decode, overflow shadow count, flush unwind.
// Optional RAS_CTRL_STATS_EN adds saturating call / return-miss counters.
module ras_ctrl #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 16,
  parameter int unsigned CW    = 4,
  parameter int unsigned OW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          call_valid,
  input  logic [AW-1:0] call_ret_addr,
  input  logic          ret_valid,
  output logic [AW-1:0] ret_target,
  output logic          ret_target_valid,
  input  logic          ckpt_save,
  input  logic          flush,
  output logic          busy,
  output logic          ras_push,
  output logic [AW-1:0] ras_data,
  output logic          ras_pop,
  input  logic [AW-1:0] ras_top,
  input  logic          ras_err,
  output logic          lossy,
  output logic          fault
`ifdef RAS_CTRL_STATS_EN
  ,
  output logic [15:0]   stat_calls,
  output logic [15:0]   stat_ret_miss
`endif
);

  typedef enum logic [0:0] {StIdle, StUnwind} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] depth_q, depth_d, target_q, target_d, ckpt_depth_q, ckpt_depth_d;
  logic [OW-1:0] ovf_q, ovf_d, ckpt_ovf_q, ckpt_ovf_d;
  logic          fault_q, fault_d;

  logic idle_ok, do_call, do_ret, conflict, at_full, ovf_sat, ret_pop;

  assign idle_ok  = (state_q == StIdle) && !flush;
  assign do_call  = idle_ok && call_valid && !ret_valid;
  assign do_ret   = idle_ok && ret_valid && !call_valid;
  assign conflict = idle_ok && call_valid && ret_valid;
  assign at_full  = (depth_q == CW'(DEPTH));
  assign ovf_sat  = (ovf_q == {OW{1'b1}});
  // Returns drain the unmirrored calls first; only then does the RAS hold the answer.
  assign ret_pop  = do_ret && (ovf_q == '0) && (depth_q != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      depth_q      <= '0;
      ovf_q        <= '0;
      target_q     <= '0;
      ckpt_depth_q <= '0;
      ckpt_ovf_q   <= '0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      depth_q      <= depth_d;
      ovf_q        <= ovf_d;
      target_q     <= target_d;
      ckpt_depth_q <= ckpt_depth_d;
      ckpt_ovf_q   <= ckpt_ovf_d;
      fault_q      <= fault_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    depth_d      = depth_q;
    ovf_d        = ovf_q;
    target_d     = target_q;
    ckpt_depth_d = ckpt_depth_q;
    ckpt_ovf_d   = ckpt_ovf_q;
    fault_d      = fault_q | ras_err | conflict;
    if (flush) begin
      ovf_d = ckpt_ovf_q;
      if (ckpt_depth_q < depth_q) begin
        state_d  = StUnwind;
        target_d = ckpt_depth_q;
      end else begin
        state_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (ckpt_save) begin
            ckpt_depth_d = depth_q;
            ckpt_ovf_d   = ovf_q;
          end
          if (do_call) begin
            if (!at_full) depth_d = depth_q + CW'(1);
            else if (!ovf_sat) ovf_d = ovf_q + OW'(1);
          end
          if (do_ret) begin
            if (ovf_q != '0) ovf_d = ovf_q - OW'(1);
            else if (depth_q != '0) depth_d = depth_q - CW'(1);
          end
        end
        StUnwind: begin
          depth_d = depth_q - CW'(1);
          if (depth_q - CW'(1) == target_q) state_d = StIdle;
        end
      endcase
    end
  end

  always_comb begin
    busy             = (state_q == StUnwind);
    ras_push         = do_call && !at_full;
    ras_pop          = ret_pop || ((state_q == StUnwind) && !flush);
    ras_data         = call_ret_addr;
    ret_target       = (depth_q != '0) ? ras_top : '0;
    ret_target_valid = ret_pop;
    fault            = fault_q;
    if (flush) lossy = (ckpt_depth_q > depth_q);
    else       lossy = do_call && at_full && ovf_sat;
  end

`ifdef RAS_CTRL_STATS_EN
  logic [15:0] stat_calls_q, stat_ret_miss_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_calls_q    <= '0;
      stat_ret_miss_q <= '0;
    end else begin
      if (do_call && (stat_calls_q != 16'hffff)) stat_calls_q <= stat_calls_q + 16'd1;
      if (do_ret && !ret_pop && (stat_ret_miss_q != 16'hffff)) begin
        stat_ret_miss_q <= stat_ret_miss_q + 16'd1;
      end
    end
  end

  assign stat_calls    = stat_calls_q;
  assign stat_ret_miss = stat_ret_miss_q;
`endif

endmodule
